rv32_progloader: RTL and testbench
==================================

Name: rv32_progloader

Overview:
- Writer side of the instruction memory that the fetch stage reads from.
- Accepts a framed byte stream from a host link (e.g. a UART RX), assembles little-endian 32-bit words and writes them into instruction memory through a write port.
- Holds the pipeline (stall/flush) while loading. On success, issues a one-cycle branch redirect so fetch restarts at RESET_PC.

Parameters:
- ADDR_WIDTH, 8: word-address width of instruction memory (capacity 2^ADDR_WIDTH words).
- RESET_PC, 32'h00000000: PC driven on the redirect after a successful load.
- MAGIC, 8'hA5: frame header byte.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle; transfer = in_valid && in_ready.
- mem_we_out  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr_out  out  ADDR_WIDTH  word address.
- mem_data_out  out  32  word data.
- stall_out  out  1  pipeline stall request to the hazard unit.
- flush_out  out  1  pipeline flush request (fetch emits NOP).
- branch_taken_out  out  1  redirect pulse to fetch.
- branch_pc_out  out  32  redirect target; always RESET_PC.
- busy_out  out  1  load in progress (any state other than IDLE).
- error_out  out  1  sticky frame error.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-low on reset_n. All outputs are registered.
- Reset values: in_ready=1; mem_we_out=0; mem_addr_out=0; mem_data_out=0; stall_out=0; flush_out=0; branch_taken_out=0; busy_out=0; error_out=0; state=IDLE.
- Reset mid-load aborts the load. Words already written remain in memory. Outputs return to reset values the cycle after reset is sampled low.
- States: IDLE, CNT_LO, CNT_HI, DATA, [CSUM], REDIRECT, ERROR.
- in_ready=1 in every state except REDIRECT.
- IDLE: non-MAGIC bytes are discarded. MAGIC -> CNT_LO; stall_out=1 and flush_out=1 from the next cycle on.
- CNT_LO, CNT_HI: 16-bit word count N, low byte first.
  - N==0 or N>2^ADDR_WIDTH -> ERROR.
  - Otherwise -> DATA; word index cleared to 0 and byte index cleared to 0.
- DATA: bytes form words little-endian (first byte = bits 7:0).
  - The cycle after the 4th byte of a word is accepted: mem_we_out=1, mem_addr_out=word index, mem_data_out=assembled word.
  - Word index increments; it never wraps because N is bounded.
  - After word N-1 is accepted -> CSUM if the feature is enabled, else REDIRECT.
- REDIRECT (one cycle): branch_taken_out=1, branch_pc_out=RESET_PC, stall_out=0, flush_out=1, in_ready=0. Next state IDLE with stall_out=0, flush_out=0, busy_out=0.
- The last mem write pulse occurs no later than the REDIRECT cycle, so fetch reads updated memory.
- ERROR: error_out=1, stall_out=1, flush_out=1, busy_out=1. Non-MAGIC bytes are discarded. MAGIC clears error_out and enters CNT_LO.
- in_valid low stalls the FSM in place; there is no timeout.
- branch_taken_out, mem_we_out: single-cycle pulses only.

Optional Feature:
- Macro: RV32_PROGLOADER_CHECKSUM_EN.
- Defined: after the last data byte, state CSUM accepts one byte and compares it with the XOR of all 4N data bytes.
  - Match -> REDIRECT.
  - Mismatch -> ERROR; memory is not rolled back and no redirect is issued.
- Undefined: no CSUM state and no checksum register; DATA goes straight to REDIRECT. Frames carry no trailing byte.

Test Plan:
- Reset, then stream 0x11 0x22 -> both discarded; busy_out=0, stall_out=0, no mem_we_out.
- Frame A5 02 00 | 13 00 00 00 | 6F 00 00 00 (+ checksum 0x7C when enabled) -> writes addr0=0x00000013 and addr1=0x0000006F; stall_out=1 throughout; then one REDIRECT cycle with branch_taken_out=1, branch_pc_out=RESET_PC; idle the cycle after.
- in_valid toggling every other cycle during the data bytes of the same frame -> identical writes, one mem_we_out pulse per word, no extra pulses.
- Count 00 00, and separately count 01 01 (257 with ADDR_WIDTH=8) -> ERROR, error_out=1, stall held, no writes. A following complete valid frame -> error_out clears and the load completes.
- Checksum enabled, one-word frame with wrong checksum byte -> word written, ERROR entered, branch_taken_out never asserted.
- reset_n low for one cycle after 2 data bytes -> all outputs at reset values next cycle. A following complete frame loads correctly from addr 0.

Source files
------------

// File: rtl/rv32_progloader_if.sv
// Host byte stream, instruction-memory write port and pipeline control for rv32_progloader.
// The slave modport is the loader side; master is the host/fetch side.
interface rv32_progloader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [31:0]           mem_data_out;
    logic                  stall_out;
    logic                  flush_out;
    logic                  branch_taken_out;
    logic [31:0]           branch_pc_out;
    logic                  busy_out;
    logic                  error_out;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we_out, mem_addr_out, mem_data_out,
               stall_out, flush_out, branch_taken_out, branch_pc_out,
               busy_out, error_out
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we_out, mem_addr_out, mem_data_out,
               stall_out, flush_out, branch_taken_out, branch_pc_out,
               busy_out, error_out
    );
endinterface

// File: rtl/rv32_progloader.sv
// Framed byte-stream loader writing little-endian words into instruction memory, then redirecting fetch.
// Optional trailing XOR checksum byte enabled by defining RV32_PROGLOADER_CHECKSUM_EN.
//
// state      | meaning
// S_IDLE     | waiting for MAGIC, other bytes dropped
// S_CNT_LO   | word count, low byte
// S_CNT_HI   | word count, high byte, range checked
// S_DATA     | assembling and writing words
// S_CSUM     | checksum byte compare (checksum build only)
// S_REDIRECT | one-cycle branch to RESET_PC, input not accepted
// S_ERROR    | sticky frame error until next MAGIC
module rv32_progloader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic clk,
    input  logic reset_n,
    rv32_progloader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
`ifdef RV32_PROGLOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_REDIRECT,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state, state_n;
    logic [7:0]            cnt_lo;
    logic [ADDR_WIDTH-1:0] widx;
    logic [ADDR_WIDTH-1:0] word_last;
    logic [1:0]            byte_idx;
    logic [31:0]           word_sr;
`ifdef RV32_PROGLOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic        accept;
    logic        is_magic;
    logic [15:0] count_full;
    logic        count_bad;
    logic        wr_word;

    assign accept     = bus.in_valid && bus.in_ready;
    assign is_magic   = bus.in_data == MAGIC;
    assign count_full = {bus.in_data, cnt_lo};
    assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > MAX_WORDS);
    assign wr_word    = accept && (state == S_DATA) && (byte_idx == 2'd3);

    assign bus.branch_pc_out = RESET_PC;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_ERROR: if (accept && is_magic) state_n = S_CNT_LO;
            S_CNT_LO:        if (accept) state_n = S_CNT_HI;
            S_CNT_HI:        if (accept) state_n = count_bad ? S_ERROR : S_DATA;
            S_DATA: begin
                if (wr_word && (widx == word_last)) begin
`ifdef RV32_PROGLOADER_CHECKSUM_EN
                    state_n = S_CSUM;
`else
                    state_n = S_REDIRECT;
`endif
                end
            end
`ifdef RV32_PROGLOADER_CHECKSUM_EN
            S_CSUM:          if (accept) state_n = (bus.in_data == csum) ? S_REDIRECT : S_ERROR;
`endif
            S_REDIRECT:      state_n = S_IDLE;
            default:         state_n = S_IDLE;
        endcase
    end

    // Control outputs are registered decodes of the next state, so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            bus.in_ready         <= 1'b1;
            bus.mem_we_out       <= 1'b0;
            bus.mem_addr_out     <= '0;
            bus.mem_data_out     <= 32'd0;
            bus.stall_out        <= 1'b0;
            bus.flush_out        <= 1'b0;
            bus.branch_taken_out <= 1'b0;
            bus.busy_out         <= 1'b0;
            bus.error_out        <= 1'b0;
            cnt_lo               <= 8'd0;
            widx                 <= '0;
            word_last            <= '0;
            byte_idx             <= 2'd0;
            word_sr              <= 32'd0;
`ifdef RV32_PROGLOADER_CHECKSUM_EN
            csum                 <= 8'd0;
`endif
        end else begin
            state                <= state_n;
            bus.in_ready         <= state_n != S_REDIRECT;
            bus.stall_out        <= (state_n != S_IDLE) && (state_n != S_REDIRECT);
            bus.flush_out        <= state_n != S_IDLE;
            bus.busy_out         <= state_n != S_IDLE;
            bus.branch_taken_out <= state_n == S_REDIRECT;
            bus.error_out        <= state_n == S_ERROR;
            bus.mem_we_out       <= wr_word;
            if (wr_word) begin
                bus.mem_addr_out <= widx;
                bus.mem_data_out <= {bus.in_data, word_sr[31:8]};
            end
            if (accept) begin
                case (state)
                    S_CNT_LO: cnt_lo <= bus.in_data;
                    S_CNT_HI: begin
                        widx      <= '0;
                        byte_idx  <= 2'd0;
                        word_last <= ADDR_WIDTH'(count_full - 16'd1);
`ifdef RV32_PROGLOADER_CHECKSUM_EN
                        csum      <= 8'd0;
`endif
                    end
                    S_DATA: begin
                        word_sr  <= {bus.in_data, word_sr[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) widx <= widx + ADDR_WIDTH'(1);
`ifdef RV32_PROGLOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32_progloader.sv
// Self-checking bench for rv32_progloader: vector table, hand-written corner sequences and random frames.
module tb_rv32_progloader;

    localparam int          AW     = 8;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef RV32_PROGLOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rv32_progloader_if #(.ADDR_WIDTH(AW)) bus ();

    rv32_progloader #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct {
        logic [7:0] lo; logic [7:0] hi; int nsend; bit corrupt; int gap;
        bit exp_err; int exp_br; int exp_wr;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          branch_cnt = 0;
    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    logic        prev_we = 1'b0;
    logic        prev_br = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Observe the write port and redirect pulses continuously.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_we_out) begin
                wr_t w;
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                w.addr = int'(bus.mem_addr_out);
                w.data = bus.mem_data_out;
                act_q.push_back(w);
            end
            if (bus.branch_taken_out) begin
                branch_cnt++;
                chk("br_single_cycle", 32'(prev_br), 32'd0);
                chk("br_pc", bus.branch_pc_out, RST_PC);
                chk("br_stall", 32'(bus.stall_out), 32'd0);
                chk("br_flush", 32'(bus.flush_out), 32'd1);
                chk("br_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end
        prev_we = bus.mem_we_out;
        prev_br = bus.branch_taken_out;
    end

    function automatic bit count_ok(input int n);
        return (n >= 1) && (n <= (1 << AW));
    endfunction

    function automatic bit model_err(input int n, input bit corrupt);
        return !count_ok(n) || (CSUM_ON && corrupt);
    endfunction

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is transferred.
    task automatic send_byte(input logic [7:0] b, input bit gap_before, input bit chk_stall);
        int   waited;
        bit   done;
        logic rdy;
        if (gap_before) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
            else begin
                waited++;
                if (waited > 16) done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        chk("accept_bound", 32'(waited > 16), 32'd0);
        if (chk_stall) begin
            chk("stall_in_load", 32'(bus.stall_out), 32'd1);
            chk("flush_in_load", 32'(bus.flush_out), 32'd1);
        end
    endtask

    task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi, input int nsend,
                              input bit corrupt, input int gapmode, input int njunk);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [7:0] junk;
        wr_t        w;
        bit         gap;
        x = 8'd0;
        for (int j = 0; j < njunk; j++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 1'b0, 1'b0);
        end
        bytes.push_back(8'hA5);
        bytes.push_back(lo);
        bytes.push_back(hi);
        for (int k = 0; k < nsend; k++) begin
            for (int j = 0; j < 4; j++) begin
                bytes.push_back(words_q[k][8*j +: 8]);
                x ^= words_q[k][8*j +: 8];
            end
            w.addr = k;
            w.data = words_q[k];
            exp_q.push_back(w);
        end
        if (CSUM_ON && nsend > 0) bytes.push_back(corrupt ? (x ^ 8'h01) : x);
        for (int i = 0; i < bytes.size(); i++) begin
            case (gapmode)
                1:       gap = (i >= 3) && (i % 2 == 1);
                2:       gap = ($urandom_range(0, 1) == 1);
                default: gap = 1'b0;
            endcase
            send_byte(bytes[i], gap, i != bytes.size() - 1);
        end
    endtask

    task automatic check_frame(input string tag, input bit exp_err, input int exp_br, input int exp_wr);
        int m;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, act_q.size(), exp_wr);
        m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        chk({tag, "_branches"}, branch_cnt, exp_br);
        chk({tag, "_error"}, 32'(bus.error_out), 32'(exp_err));
        chk({tag, "_busy"}, 32'(bus.busy_out), 32'(exp_err));
        chk({tag, "_stall"}, 32'(bus.stall_out), 32'(exp_err));
        chk({tag, "_flush"}, 32'(bus.flush_out), 32'(exp_err));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        act_q.delete();
        exp_q.delete();
        branch_cnt = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we_out), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr_out), 32'd0);
        chk({tag, "_data"}, bus.mem_data_out, 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
        chk({tag, "_flush"}, 32'(bus.flush_out), 32'd0);
        chk({tag, "_branch"}, 32'(bus.branch_taken_out), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
        chk({tag, "_error"}, 32'(bus.error_out), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'h02, 8'h00, 2,   0, 0, 0, 1, 2};
        vecs[1] = '{8'h02, 8'h00, 2,   0, 1, 0, 1, 2};
        vecs[2] = '{8'h00, 8'h00, 0,   0, 0, 1, 0, 0};
        vecs[3] = '{8'h01, 8'h00, 1,   0, 2, 0, 1, 1};
        vecs[4] = '{8'h01, 8'h01, 0,   0, 0, 1, 0, 0};
        vecs[5] = '{8'h02, 8'h00, 2,   0, 0, 0, 1, 2};
        vecs[6] = '{8'h01, 8'h00, 1,   1, 0, CSUM_ON, (CSUM_ON ? 0 : 1), 1};
        vecs[7] = '{8'h00, 8'h01, 256, 0, 0, 0, 1, 256};
        vecs[8] = '{8'hFF, 8'hFF, 0,   0, 0, 1, 0, 0};
        vecs[9] = '{8'h03, 8'h00, 3,   0, 2, 0, 1, 3};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset_n      = 1'b0;
        @(posedge clk); #1;
        chk_reset_values("por");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Junk before any header is ignored.
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("junk_busy", 32'(bus.busy_out), 32'd0);
        chk("junk_stall", 32'(bus.stall_out), 32'd0);
        chk("junk_writes", act_q.size(), 32'd0);

        words_q.delete();
        words_q.push_back(32'h0000_0013);
        words_q.push_back(32'h0000_006F);
        send_frame(8'h02, 8'h00, 2, 1'b0, 0, 0);
        check_frame("plan", 1'b0, 1, 2);

        for (int v = 0; v < 10; v++) begin
            fill_random(vecs[v].nsend);
            send_frame(vecs[v].lo, vecs[v].hi, vecs[v].nsend, vecs[v].corrupt, vecs[v].gap, 0);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_br, vecs[v].exp_wr);
        end

        // Reset after two data bytes aborts the load without any write.
        fill_random(2);
        send_frame(8'h02, 8'h00, 2, 1'b0, 0, 0);
        check_frame("pre_rst", 1'b0, 1, 2);
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h13, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_values("midrst");
        reset_n = 1'b1;
        chk("midrst_writes", act_q.size(), 32'd0);
        fill_random(2);
        send_frame(8'h02, 8'h00, 2, 1'b0, 0, 0);
        check_frame("post_rst", 1'b0, 1, 2);

        for (int r = 0; r < 25; r++) begin
            int   kind;
            int   n;
            bit   corrupt;
            bit   err;
            int   nsend;
            logic [15:0] n16;
            kind    = int'($urandom_range(0, 9));
            if (kind == 0)      n = 0;
            else if (kind == 1) n = 257 + int'($urandom_range(0, 300));
            else                n = int'($urandom_range(1, 8));
            corrupt = ($urandom_range(0, 3) == 0);
            err     = model_err(n, corrupt);
            nsend   = count_ok(n) ? n : 0;
            n16     = 16'(n);
            fill_random(nsend);
            send_frame(n16[7:0], n16[15:8], nsend, corrupt, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)));
            check_frame($sformatf("rnd%0d", r), err, (err ? 0 : 1), nsend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
